// File: rtl/cpu_pkg.sv
// cpu_pkg: constants shared by the fetch unit and the control unit.
// Contents:
//   opcode_e       3-bit opcode encodings
//   ADDR_W_DEF     default PC / operand width
//   OPC_W          opcode field width; the opcode sits directly above the operand
//   OPERAND_LSB    bit position of the operand field
package cpu_pkg;

  localparam int ADDR_W_DEF  = 5;
  localparam int OPC_W       = 3;
  localparam int OPERAND_LSB = 0;

  typedef enum logic [OPC_W-1:0] {
    OP_LOAD_A    = 3'b000,
    OP_LOAD_B    = 3'b001,
    OP_STORE     = 3'b010,
    OP_STORE_IMM = 3'b011,
    OP_JMP       = 3'b100,
    OP_RET       = 3'b110,
    OP_ALU       = 3'b111
  } opcode_e;

endpackage

// File: rtl/return_stack.sv
// return_stack: circular return-address stack. When it is full, a push
// overwrites the oldest entry.
// Ports:
//   clk, rst   clock and asynchronous active-high reset
//   push       write din at sp, then advance sp (takes priority over pop)
//   pop        retreat sp when the stack is not empty; ignored when empty
//   din        return address to push
//   top        entry at sp-1, i.e. the value the next pop returns
//   empty      no valid entries
//   full       DEPTH valid entries
module return_stack #(
  parameter int DEPTH = 4,
  parameter int W     = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] top,
  output logic         empty,
  output logic         full
);

  localparam int SP_W  = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [W-1:0]     r_mem [DEPTH];
  logic [SP_W-1:0]  r_sp;
  logic [CNT_W-1:0] r_count;
  logic [SP_W-1:0]  w_sp_dec;

  // DEPTH is a power of two, so the pointer wraps naturally.
  assign w_sp_dec = r_sp - SP_W'(1);
  assign top      = r_mem[w_sp_dec];
  assign empty    = (r_count == '0);
  assign full     = (r_count == CNT_W'(DEPTH));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_sp    <= '0;
      r_count <= '0;
    end else if (push) begin
      r_mem[r_sp] <= din;
      r_sp        <= r_sp + SP_W'(1);
      // When full, the slot just written held the oldest entry; depth stays saturated.
      if (!full) r_count <= r_count + CNT_W'(1);
    end else if (pop && !empty) begin
      r_sp    <= w_sp_dec;
      r_count <= r_count - CNT_W'(1);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: program counter and instruction-fetch stage. It holds the PC,
// splits the fetched word into opcode and operand, and makes JMP a call and
// RET a return through a circular return-address stack.
// Ports:
//   clk, rst        clock and asynchronous active-high reset
//   stall           hold PC and stack for this cycle
//   jmp             call to operand and push pc+1 (wins over ret)
//   ret             pop a return address into the PC
//   imem_data       fetched instruction word {opcode, operand}
//   imem_addr       instruction-memory address (equal to pc)
//   opcode/operand  combinational fields of imem_data
//   pc              current program counter
//   ras_overflow    sticky: a push hit a full stack
//   ras_underflow   sticky: a pop hit an empty stack
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int RAS_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    stall,
  input  logic                    jmp,
  input  logic                    ret,
  input  logic [OPC_W+ADDR_W-1:0] imem_data,
  output logic [ADDR_W-1:0]       imem_addr,
  output logic [OPC_W-1:0]        opcode,
  output logic [ADDR_W-1:0]       operand,
  output logic [ADDR_W-1:0]       pc,
  output logic                    ras_overflow,
  output logic                    ras_underflow
);

  logic [ADDR_W-1:0] r_pc;
  logic              r_ovf;
  logic              r_udf;

  logic [ADDR_W-1:0] w_pc_inc;
  logic [ADDR_W-1:0] w_pc_next;
  logic [ADDR_W-1:0] w_ras_top;
  logic              w_ras_empty;
  logic              w_ras_full;
  logic              w_push;
  logic              w_ret_req;
  logic              w_pop;

  assign opcode    = imem_data[ADDR_W +: OPC_W];
  assign operand   = imem_data[OPERAND_LSB +: ADDR_W];
  assign imem_addr = r_pc;
  assign pc        = r_pc;

  // Modulo 2^ADDR_W: this also yields the wrapped return address pushed from all-ones.
  assign w_pc_inc  = r_pc + ADDR_W'(1);

  // A ret is only considered when neither stall nor jmp outranks it.
  assign w_push    = !stall && jmp;
  assign w_ret_req = !stall && !jmp && ret;
  assign w_pop     = w_ret_req && !w_ras_empty;

  always_comb begin
    w_pc_next = w_pc_inc;
    if (stall)      w_pc_next = r_pc;
    else if (jmp)   w_pc_next = operand;
    else if (w_pop) w_pc_next = w_ras_top;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc  <= '0;
      r_ovf <= 1'b0;
      r_udf <= 1'b0;
    end else begin
      r_pc <= w_pc_next;
      if (w_push && w_ras_full)      r_ovf <= 1'b1;
      if (w_ret_req && w_ras_empty)  r_udf <= 1'b1;
    end
  end

  assign ras_overflow  = r_ovf;
  assign ras_underflow = r_udf;

  return_stack #(
    .DEPTH (RAS_DEPTH),
    .W     (ADDR_W)
  ) u_ras (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push),
    .pop   (w_pop),
    .din   (w_pc_inc),
    .top   (w_ras_top),
    .empty (w_ras_empty),
    .full  (w_ras_full)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit (ADDR_W=5, RAS_DEPTH=4). The bench plays
// the instruction memory and the control unit by driving imem_data, jmp and ret.
module tb_fetch_unit;
  import cpu_pkg::*;

  localparam int AW = 5;

  logic          clk;
  logic          rst;
  logic          stall;
  logic          jmp;
  logic          ret;
  logic [AW+2:0] imem_data;
  logic [AW-1:0] imem_addr;
  logic [2:0]    opcode;
  logic [AW-1:0] operand;
  logic [AW-1:0] pc;
  logic          ras_overflow;
  logic          ras_underflow;

  int n_checks = 0;
  int n_err    = 0;

  fetch_unit #(.ADDR_W(AW), .RAS_DEPTH(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .jmp           (jmp),
    .ret           (ret),
    .imem_data     (imem_data),
    .imem_addr     (imem_addr),
    .opcode        (opcode),
    .operand       (operand),
    .pc            (pc),
    .ras_overflow  (ras_overflow),
    .ras_underflow (ras_underflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_flags(input string tag, input logic ov, input logic un);
    chk({tag, "_ovf"}, {31'd0, ras_overflow}, {31'd0, ov});
    chk({tag, "_udf"}, {31'd0, ras_underflow}, {31'd0, un});
  endtask

  task automatic chk_cnt(input string tag, input int exp);
    chk({tag, "_cnt"}, 32'(dut.u_ras.r_count), 32'(exp));
  endtask

  // Present one instruction, check the combinational decode, clock it, and
  // check the new PC shortly after the edge.
  task automatic cyc(input string tag, input logic [2:0] opc, input logic [AW-1:0] opnd,
                     input logic j, input logic r, input logic s, input logic [AW-1:0] exp_pc);
    imem_data = {opc, opnd};
    jmp       = j;
    ret       = r;
    stall     = s;
    #1;
    chk({tag, "_opc"}, {29'd0, opcode}, {29'd0, opc});
    chk({tag, "_opnd"}, {27'd0, operand}, {27'd0, opnd});
    @(posedge clk);
    #1;
    chk({tag, "_pc"}, {27'd0, pc}, {27'd0, exp_pc});
    chk({tag, "_addr"}, {27'd0, imem_addr}, {27'd0, exp_pc});
  endtask

  task automatic do_reset();
    jmp = 1'b0; ret = 1'b0; stall = 1'b0;
    rst = 1'b1;
    #2;
    rst = 1'b0;
  endtask

  initial begin
    imem_data = '0;
    do_reset();
    chk("rst_pc", {27'd0, pc}, 32'd0);
    chk("rst_addr", {27'd0, imem_addr}, 32'd0);
    chk_cnt("rst", 0);
    chk_flags("rst", 1'b0, 1'b0);

    // Sequential fetch
    cyc("seq1", OP_ALU,    5'd7,  1'b0, 1'b0, 1'b0, 5'd1);
    cyc("seq2", OP_LOAD_A, 5'd3,  1'b0, 1'b0, 1'b0, 5'd2);
    cyc("seq3", OP_STORE,  5'd21, 1'b0, 1'b0, 1'b0, 5'd3);
    chk_flags("seq", 1'b0, 1'b0);

    // Call / return
    do_reset();
    cyc("cr_a", OP_LOAD_B, 5'd0,  1'b0, 1'b0, 1'b0, 5'd1);
    cyc("cr_b", OP_ALU,    5'd0,  1'b0, 1'b0, 1'b0, 5'd2);
    cyc("cr_jmp", OP_JMP,  5'h10, 1'b1, 1'b0, 1'b0, 5'h10);
    chk_cnt("cr_jmp", 1);
    cyc("cr_ret", OP_RET,  5'd0,  1'b0, 1'b1, 1'b0, 5'd3);
    chk_cnt("cr_ret", 0);

    // Five nested calls into a 4-deep stack, then five returns
    do_reset();
    cyc("n_j1", OP_JMP, 5'd4,  1'b1, 1'b0, 1'b0, 5'd4);   // push 1
    cyc("n_j2", OP_JMP, 5'd8,  1'b1, 1'b0, 1'b0, 5'd8);   // push 5
    cyc("n_j3", OP_JMP, 5'd12, 1'b1, 1'b0, 1'b0, 5'd12);  // push 9
    cyc("n_j4", OP_JMP, 5'd16, 1'b1, 1'b0, 1'b0, 5'd16);  // push 13
    chk_cnt("n_j4", 4);
    chk_flags("n_j4", 1'b0, 1'b0);
    cyc("n_j5", OP_JMP, 5'd20, 1'b1, 1'b0, 1'b0, 5'd20);  // push 17, drop 1
    chk_cnt("n_j5", 4);
    chk_flags("n_j5", 1'b1, 1'b0);
    cyc("n_r1", OP_RET, 5'd0, 1'b0, 1'b1, 1'b0, 5'd17);
    cyc("n_r2", OP_RET, 5'd0, 1'b0, 1'b1, 1'b0, 5'd13);
    cyc("n_r3", OP_RET, 5'd0, 1'b0, 1'b1, 1'b0, 5'd9);
    cyc("n_r4", OP_RET, 5'd0, 1'b0, 1'b1, 1'b0, 5'd5);
    chk_cnt("n_r4", 0);
    chk_flags("n_r4", 1'b1, 1'b0);
    cyc("n_r5", OP_RET, 5'd0, 1'b0, 1'b1, 1'b0, 5'd6);
    chk_cnt("n_r5", 0);
    chk_flags("n_r5", 1'b1, 1'b1);

    // Stall held over a pending jmp
    cyc("st1", OP_JMP, 5'd10, 1'b1, 1'b0, 1'b1, 5'd6);
    cyc("st2", OP_JMP, 5'd10, 1'b1, 1'b0, 1'b1, 5'd6);
    cyc("st3", OP_JMP, 5'd10, 1'b1, 1'b0, 1'b1, 5'd6);
    chk_cnt("st3", 0);
    cyc("st_go", OP_JMP, 5'd10, 1'b1, 1'b0, 1'b0, 5'd10);
    chk_cnt("st_go", 1);
    cyc("st_after", OP_ALU, 5'd2, 1'b0, 1'b0, 1'b0, 5'd11);
    chk_cnt("st_after", 1);
    chk_flags("st", 1'b1, 1'b1);

    // PC and return-address wrap at 31
    do_reset();
    cyc("w_j31", OP_JMP, 5'd31, 1'b1, 1'b0, 1'b0, 5'd31);
    cyc("w_wrap", OP_ALU, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0);
    cyc("w_j31b", OP_JMP, 5'd31, 1'b1, 1'b0, 1'b0, 5'd31);
    cyc("w_jfrom31", OP_JMP, 5'd3, 1'b1, 1'b0, 1'b0, 5'd3);
    chk_cnt("w_jfrom31", 3);
    cyc("w_ret0", OP_RET, 5'd0, 1'b0, 1'b1, 1'b0, 5'd0);
    cyc("w_ret1", OP_RET, 5'd0, 1'b0, 1'b1, 1'b0, 5'd1);
    chk_cnt("w_ret1", 1);

    // jmp and ret together: jmp wins, stack contents intact
    do_reset();
    cyc("jr_a", OP_JMP, 5'd6, 1'b1, 1'b0, 1'b0, 5'd6);   // push 1
    cyc("jr_b", OP_JMP, 5'd4, 1'b1, 1'b0, 1'b0, 5'd4);   // push 7
    cyc("jr_both", OP_JMP, 5'd9, 1'b1, 1'b1, 1'b0, 5'd9); // push 5
    chk_cnt("jr_both", 3);
    cyc("jr_r5", OP_RET, 5'd0, 1'b0, 1'b1, 1'b0, 5'd5);
    cyc("jr_r7", OP_RET, 5'd0, 1'b0, 1'b1, 1'b0, 5'd7);
    cyc("jr_r1", OP_RET, 5'd0, 1'b0, 1'b1, 1'b0, 5'd1);
    cyc("jr_rx", OP_RET, 5'd0, 1'b0, 1'b1, 1'b0, 5'd2);
    chk_flags("jr", 1'b0, 1'b1);
    cyc("jr_j", OP_JMP, 5'd20, 1'b1, 1'b0, 1'b0, 5'd20);
    chk_cnt("jr_j", 1);

    // Asynchronous reset in the middle of a cycle
    #2;
    rst = 1'b1;
    #1;
    chk("arst_pc", {27'd0, pc}, 32'd0);
    chk("arst_addr", {27'd0, imem_addr}, 32'd0);
    chk_cnt("arst", 0);
    chk_flags("arst", 1'b0, 1'b0);
    #1;
    rst = 1'b0;
    jmp = 1'b0;
    cyc("arst_run", OP_ALU, 5'd0, 1'b0, 1'b0, 1'b0, 5'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
